mmio_bus: RTL and testbench
===========================

# mmio_bus

Parametrised memory-mapped interconnect between the core's data port and on-chip RAM plus NUM_PERIPH peripheral slots. RAM accesses complete with zero wait states; peripheral accesses stall the core through a request/ready handshake with a bounded timeout. Accesses to unmapped space, or peripheral accesses that time out, are flagged in a sticky status register readable over the same bus.

## Interface
Parameters:
- DATA_W, 32, data width (bits).
- RAM_BYTES, 16384, RAM window size at 0x0; power of two.
- PERIPH_BASE, 0x00004000, base of slot 0.
- SLOT_BYTES, 16, bytes per peripheral slot; power of two, at least 4.
- NUM_PERIPH, 4, number of peripheral slots, 1..8.
- TIMEOUT, 15, maximum wait cycles for per_ready, 1..255.

Ports:
- clk, in, 1, system clock; all state on the rising edge.
- rst, in, 1, asynchronous, active-low reset.
- cpu_addr, in, 32, byte address from the core.
- cpu_wdata, in, DATA_W, write data.
- cpu_read / cpu_write, in, 1 each, access strobes; held by the core while cpu_stall is high.
- cpu_rdata, out, DATA_W, read data to the core.
- cpu_stall, out, 1, core must hold its request and not advance.
- ram_read / ram_write, out, 1 each, RAM strobes.
- ram_wdata, out, DATA_W, RAM write data.
- ram_rdata, in, DATA_W, RAM read data.
- per_sel, out, NUM_PERIPH, one-hot slot select.
- per_read / per_write, out, 1 each, peripheral strobes.
- per_offset, out, log2(SLOT_BYTES), byte offset within the slot.
- per_wdata, out, DATA_W, latched write data.
- per_rdata, in, NUM_PERIPH*DATA_W, slot i occupies bits [i*DATA_W +: DATA_W].
- per_ready, in, NUM_PERIPH, per-slot completion.
- bus_err, out, 1, one-cycle pulse on any error.

## Operation
Decode is on cpu_addr:
- RAM hit: addr < RAM_BYTES.
- Slot i: PERIPH_BASE + i*SLOT_BYTES ≤ addr < PERIPH_BASE + (i+1)*SLOT_BYTES.
- STATUS: addr == PERIPH_BASE + NUM_PERIPH*SLOT_BYTES.
- Unmapped: everything else.
- If cpu_read and cpu_write are both high, the access is treated as a write.

RAM path (combinational, any state):
- ram_read and ram_write follow cpu_read and cpu_write when the address hits RAM.
- ram_wdata = cpu_wdata; cpu_rdata = ram_rdata.
- No stall.

STATUS register:
- Read returns {count[7:0] in bits 15:8, 5'b0, illegal, timeout, unmapped in bits 2:0}; upper bits are 0.
- Any write clears all fields.
- No stall.

Unmapped access:
- No stall; read returns 0; write is dropped.
- Sets the unmapped flag, count saturates at 255, bus_err pulses.

Peripheral FSM, states IDLE, WAIT, DONE:
- IDLE:
  - On a slot hit, latch slot, offset, direction and wdata, clear the wait counter, and go to WAIT.
  - cpu_stall is high combinationally during this cycle.
- WAIT:
  - per_sel, the strobe, per_offset and per_wdata are driven from the latched values and held constant.
  - cpu_stall = 1.
  - Counter increments each cycle.
  - If per_ready[slot] is high: capture per_rdata for that slot into rdata_q (writes capture 0) and go to DONE.
  - Else if counter == TIMEOUT: rdata_q = 0xDEADBEEF truncated to DATA_W, set the timeout flag, count++, pulse bus_err, go to DONE.
  - per_ready of non-selected slots is ignored.
- DONE:
  - cpu_stall = 0; cpu_rdata = rdata_q.
  - Strobes are deasserted.
  - Go to IDLE unconditionally; the request still present this cycle is the one being retired and is not re-decoded.
- The illegal flag is set when a slot access arrives with both strobes high (it executes as a write).

## Timing
Reset values:
- cpu_stall = 0, per_sel = 0, per_read = per_write = 0, bus_err = 0.
- rdata_q = 0, flags = 0, count = 0, state IDLE.
- RAM outputs are combinational (0 when there is no request).

Latency:
- RAM, STATUS and unmapped: 0 stall cycles.
- Peripheral with ready k cycles after the WAIT entry edge (k = 0 means ready in the first WAIT cycle): k+1 WAIT cycles, then 1 DONE cycle. The core sees a stall of k+2 cycles including the IDLE request cycle.
- Timeout: TIMEOUT+1 WAIT cycles, then DONE.

Other rules:
- bus_err is registered, high for exactly one cycle, and asserts the cycle after the error is detected.
- Clear-on-write to STATUS in the same cycle as a new error: the error wins (the field is set and count = 1).
- Asserting rst mid-WAIT immediately drops the strobes, per_sel and cpu_stall (asynchronous). The transaction is abandoned, not retried.

## Test plan
- RAM write 0x12345678 to 0x10, then read 0x10: ram_write is high for 1 cycle, the read returns 0x12345678, and cpu_stall never asserts.
- Read of slot 1 at 0x4014 with per_ready[1] raised on the 3rd WAIT cycle and per_rdata slot 1 = 0xA5: per_sel = 0b0010 and per_offset = 4 throughout WAIT; cpu_stall is high for 4 cycles; cpu_rdata = 0xA5 in DONE.
- Write to slot 0 with per_ready never raised (TIMEOUT = 15): 16 WAIT cycles; bus_err pulses once; reading STATUS at 0x4040 returns 0x0102.
- Read of 0x8000 (unmapped): returns 0 with no stall; STATUS = 0x0101. Writing STATUS, then reading it, returns 0.
- Assert rst during WAIT: all outputs return to reset values within the same cycle. After release, a RAM read proceeds normally.
- 256 consecutive unmapped reads: count saturates at 0xFF.

Source files
------------

// File: rtl/mmio_bus.sv
// mmio_bus: core data-port interconnect to RAM, peripheral slots and a sticky error status register
module mmio_bus #(
  parameter int          DATA_W      = 32,
  parameter int          RAM_BYTES   = 16384,
  parameter logic [31:0] PERIPH_BASE = 32'h0000_4000,
  parameter int          SLOT_BYTES  = 16,
  parameter int          NUM_PERIPH  = 4,
  parameter int          TIMEOUT     = 15,
  localparam int         OFF_W       = $clog2(SLOT_BYTES),
  localparam int         SW          = NUM_PERIPH > 1 ? $clog2(NUM_PERIPH) : 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [31:0]                  cpu_addr,
  input  logic [DATA_W-1:0]            cpu_wdata,
  input  logic                         cpu_read,
  input  logic                         cpu_write,
  output logic [DATA_W-1:0]            cpu_rdata,
  output logic                         cpu_stall,
  output logic                         ram_read,
  output logic                         ram_write,
  output logic [DATA_W-1:0]            ram_wdata,
  input  logic [DATA_W-1:0]            ram_rdata,
  output logic [NUM_PERIPH-1:0]        per_sel,
  output logic                         per_read,
  output logic                         per_write,
  output logic [OFF_W-1:0]             per_offset,
  output logic [DATA_W-1:0]            per_wdata,
  input  logic [NUM_PERIPH*DATA_W-1:0] per_rdata,
  input  logic [NUM_PERIPH-1:0]        per_ready,
  output logic                         bus_err
);
  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
  localparam logic [31:0] PEND = PERIPH_BASE + 32'(NUM_PERIPH * SLOT_BYTES);
  state_t            state;
  logic [SW-1:0]     slot_q, slot_d;
  logic [OFF_W-1:0]  off_q;
  logic              dir_q;
  logic [DATA_W-1:0] wdata_q, rdata_q, status;
  logic [7:0]        cnt, count, cnt_base;
  logic              f_um, f_to, f_ill;
  logic              acc, idle, ram_hit, slot_hit, st_hit, um_hit;
  logic              um_err, to_now, ill_now, err_now, clr;

  assign acc      = cpu_read | cpu_write;
  assign idle     = state == IDLE;
  assign ram_hit  = cpu_addr < 32'(RAM_BYTES);
  assign slot_hit = !ram_hit && cpu_addr >= PERIPH_BASE && cpu_addr < PEND;
  assign st_hit   = !ram_hit && cpu_addr == PEND;
  assign um_hit   = !ram_hit && !slot_hit && !st_hit;
  assign slot_d   = SW'((cpu_addr - PERIPH_BASE) >> OFF_W);
  assign um_err   = idle && acc && um_hit;
  assign ill_now  = idle && slot_hit && cpu_read && cpu_write;
  assign clr      = idle && st_hit && cpu_write;
  assign to_now   = state == WAIT && !per_ready[slot_q] && cnt == 8'(TIMEOUT);
  assign err_now  = um_err | to_now;
  assign cnt_base = clr ? 8'd0 : count;
  assign status   = DATA_W'({count, 5'b0, f_ill, f_to, f_um});

  assign ram_write  = ram_hit && cpu_write;
  assign ram_read   = ram_hit && cpu_read && !cpu_write;
  assign ram_wdata  = cpu_wdata;
  assign cpu_rdata  = state == DONE ? rdata_q :
                      ram_hit ? ram_rdata :
                      (idle && st_hit) ? status : '0;
  assign cpu_stall  = rst && (state == WAIT || (idle && acc && slot_hit));
  assign per_sel    = state == WAIT ? NUM_PERIPH'(1) << slot_q : '0;
  assign per_read   = state == WAIT && !dir_q;
  assign per_write  = state == WAIT && dir_q;
  assign per_offset = off_q;
  assign per_wdata  = wdata_q;

  // Sticky error fields; a STATUS write clears them but a same-cycle error still lands
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      f_um    <= 1'b0;
      f_to    <= 1'b0;
      f_ill   <= 1'b0;
      count   <= '0;
      bus_err <= 1'b0;
    end else begin
      f_um    <= (f_um & ~clr) | um_err;
      f_to    <= (f_to & ~clr) | to_now;
      f_ill   <= (f_ill & ~clr) | ill_now;
      count   <= (err_now && cnt_base != 8'hFF) ? cnt_base + 8'd1 : cnt_base;
      bus_err <= err_now;
    end

  // Peripheral handshake: latch the request, wait for ready or timeout, retire for one cycle
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state   <= IDLE;
      slot_q  <= '0;
      off_q   <= '0;
      dir_q   <= 1'b0;
      wdata_q <= '0;
      rdata_q <= '0;
      cnt     <= '0;
    end else begin
      case (state)
        IDLE: if (acc && slot_hit) begin
          slot_q  <= slot_d;
          off_q   <= cpu_addr[OFF_W-1:0];
          dir_q   <= cpu_write;
          wdata_q <= cpu_wdata;
          cnt     <= '0;
          state   <= WAIT;
        end
        WAIT: begin
          cnt <= cnt + 8'd1;
          if (per_ready[slot_q]) begin
            rdata_q <= dir_q ? '0 : per_rdata[int'(slot_q)*DATA_W +: DATA_W];
            state   <= DONE;
          end else if (to_now) begin
            rdata_q <= DATA_W'(32'hDEADBEEF);
            state   <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_mmio_bus.sv
// tb_mmio_bus: table, directed and randomized checks of mmio_bus against a transaction-level model
module tb_mmio_bus;
  localparam int DW = 32;
  localparam int NP = 4;
  localparam int TO = 15;

  typedef struct {
    bit          rd;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          k;
    logic [31:0] pval;
    logic [31:0] exp_rdata;
    int          exp_stall;
    bit          chk_rd;
  } vec_t;

  logic clk = 0;
  logic rst = 0;
  logic [31:0] cpu_addr = 0, cpu_wdata = 0, cpu_rdata, ram_wdata, ram_rdata, per_wdata;
  logic cpu_read = 0, cpu_write = 0, cpu_stall, ram_read, ram_write, per_read, per_write, bus_err;
  logic [NP-1:0] per_sel, per_ready = '0;
  logic [3:0] per_offset;
  logic [NP*DW-1:0] per_rdata = '0;
  logic [31:0] tb_ram [0:4095];
  int checks = 0, errors = 0, pulses = 0;

  logic st_um, st_to, st_ill;
  int st_cnt, exp_err;
  logic [31:0] ref_mem [int];

  always #5 clk = ~clk;
  assign ram_rdata = tb_ram[cpu_addr[13:2]];
  always @(posedge clk) if (ram_write) tb_ram[cpu_addr[13:2]] <= ram_wdata;
  always @(negedge clk) if (bus_err) pulses <= pulses + 1;

  mmio_bus dut (
    .clk(clk), .rst(rst), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_read(cpu_read), .cpu_write(cpu_write), .cpu_rdata(cpu_rdata), .cpu_stall(cpu_stall),
    .ram_read(ram_read), .ram_write(ram_write), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata),
    .per_sel(per_sel), .per_read(per_read), .per_write(per_write), .per_offset(per_offset),
    .per_wdata(per_wdata), .per_rdata(per_rdata), .per_ready(per_ready), .bus_err(bus_err)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  task automatic bump();
    st_cnt = st_cnt < 255 ? st_cnt + 1 : 255;
    exp_err++;
  endtask

  function automatic logic [31:0] st_val();
    return {16'h0, 8'(st_cnt), 5'h0, st_ill, st_to, st_um};
  endfunction

  // One core access held until cpu_stall drops; ready for the addressed slot is raised on WAIT cycle k
  task automatic run_txn(input bit rd, input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                         input int k, input logic [31:0] pval,
                         output logic [31:0] rdata, output int stall, output bit ok);
    bit is_ram, is_slot, done;
    logic [NP-1:0] oh;
    int s;
    is_ram = addr < 32'd16384;
    is_slot = addr >= 32'h4000 && addr < 32'h4040;
    s = is_slot ? int'((addr - 32'h4000) >> 4) : 0;
    oh = is_slot ? NP'(1) << s : '0;
    cpu_addr = addr;
    cpu_wdata = wdata;
    cpu_read = rd;
    cpu_write = wr;
    for (int i = 0; i < NP; i++) per_rdata[i*DW +: DW] = (is_slot && i == s) ? pval : $urandom;
    stall = 0;
    ok = 1;
    done = 0;
    rdata = 0;
    for (int c = 0; c < 300; c++) begin
      per_ready = (NP'($urandom) & ~oh) | ((c == k + 1) ? oh : '0);
      @(negedge clk);
      if (ram_write !== (is_ram && wr) || ram_read !== (is_ram && rd && !wr)) ok = 0;
      if (is_slot && c > 0 && cpu_stall) begin
        if (per_sel !== oh || per_read !== (rd && !wr) || per_write !== wr ||
            per_offset !== addr[3:0] || per_wdata !== wdata) ok = 0;
      end else if (per_sel !== '0 || per_read !== 1'b0 || per_write !== 1'b0) ok = 0;
      if (cpu_stall) stall++;
      else begin
        rdata = cpu_rdata;
        done = 1;
      end
      @(posedge clk);
      #1;
      if (done) break;
    end
    cpu_read = 0;
    cpu_write = 0;
    per_ready = '0;
  endtask

  initial begin
    vec_t tbl [16];
    logic [31:0] got, a, wd, pv, er;
    int st, k, es, kind, w, s, p0;
    bit ok, rd, wr, cr;

    tbl[0]  = '{1, 0, 32'h4040, 0, 0, 0, 32'h0, 0, 1};
    tbl[1]  = '{0, 1, 32'h10, 32'h12345678, 0, 0, 0, 0, 0};
    tbl[2]  = '{1, 0, 32'h10, 0, 0, 0, 32'h12345678, 0, 1};
    tbl[3]  = '{1, 0, 32'h4014, 0, 2, 32'hA5, 32'hA5, 4, 1};
    tbl[4]  = '{0, 1, 32'h4000, 32'hCAFE0001, 99, 0, 32'hDEADBEEF, 17, 1};
    tbl[5]  = '{1, 0, 32'h4040, 0, 0, 0, 32'h0102, 0, 1};
    tbl[6]  = '{0, 1, 32'h4040, 32'hFFFFFFFF, 0, 0, 0, 0, 0};
    tbl[7]  = '{1, 0, 32'h8000, 0, 0, 0, 32'h0, 0, 1};
    tbl[8]  = '{1, 0, 32'h4040, 0, 0, 0, 32'h0101, 0, 1};
    tbl[9]  = '{0, 1, 32'h4040, 0, 0, 0, 0, 0, 0};
    tbl[10] = '{1, 0, 32'h4040, 0, 0, 0, 32'h0, 0, 1};
    tbl[11] = '{1, 1, 32'h4024, 32'h11, 0, 32'h99, 32'h0, 2, 1};
    tbl[12] = '{1, 0, 32'h403C, 0, 15, 32'h5A5A, 32'h5A5A, 17, 1};
    tbl[13] = '{1, 0, 32'h4040, 0, 0, 0, 32'h4, 0, 1};
    tbl[14] = '{1, 0, 32'h4008, 0, 0, 32'h77, 32'h77, 2, 1};
    tbl[15] = '{0, 1, 32'h4040, 0, 0, 0, 0, 0, 0};

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_stall", 32'(cpu_stall), 0);
    chk("rst_sel", 32'(per_sel), 0);
    chk("rst_strobes", {28'h0, per_read, per_write, ram_read, ram_write}, 0);
    chk("rst_bus_err", 32'(bus_err), 0);
    @(posedge clk);
    #1;
    rst = 1;

    p0 = pulses;
    for (int i = 0; i < 16; i++) begin
      run_txn(tbl[i].rd, tbl[i].wr, tbl[i].addr, tbl[i].wdata, tbl[i].k, tbl[i].pval, got, st, ok);
      chk($sformatf("vec%0d_stall", i), st, tbl[i].exp_stall);
      if (tbl[i].chk_rd) chk($sformatf("vec%0d_rdata", i), got, tbl[i].exp_rdata);
      chk($sformatf("vec%0d_sig", i), 32'(ok), 1);
    end
    idle_cycle();
    idle_cycle();
    chk("vec_bus_err_pulses", pulses - p0, 2);

    run_txn(1, 0, 32'h8000, 0, 0, 0, got, st, ok);
    @(negedge clk);
    chk("err_pulse_next", 32'(bus_err), 1);
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("err_pulse_end", 32'(bus_err), 0);
    @(posedge clk);
    #1;
    run_txn(0, 1, 32'h4040, 0, 0, 0, got, st, ok);

    cpu_addr = 32'h4038;
    cpu_read = 1;
    per_ready = '0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    chk("wait_pre_rst", {27'h0, cpu_stall, per_sel}, {27'h0, 1'b1, 4'b1000});
    #2 rst = 0;
    #1;
    chk("rst_mid_wait", {25'h0, cpu_stall, per_read, per_write, bus_err, per_sel}, 0);
    cpu_read = 0;
    @(posedge clk);
    #1;
    rst = 1;
    run_txn(1, 0, 32'h10, 0, 0, 0, got, st, ok);
    chk("post_rst_ram_rdata", got, 32'h12345678);
    chk("post_rst_ram_stall", st, 0);
    run_txn(1, 0, 32'h4040, 0, 0, 0, got, st, ok);
    chk("post_rst_status", got, 0);

    p0 = pulses;
    for (int i = 0; i < 256; i++) run_txn(1, 0, 32'h8000, 0, 0, 0, got, st, ok);
    idle_cycle();
    idle_cycle();
    chk("sat_pulses", pulses - p0, 256);
    run_txn(1, 0, 32'h4040, 0, 0, 0, got, st, ok);
    chk("sat_status", got, 32'h0000FF01);
    run_txn(0, 1, 32'h4040, 0, 0, 0, got, st, ok);

    st_um = 0; st_to = 0; st_ill = 0; st_cnt = 0; exp_err = 0;
    p0 = pulses;
    for (int n = 0; n < 300; n++) begin
      kind = $urandom_range(0, 9);
      wd = $urandom;
      pv = $urandom;
      k = 0; rd = 1; wr = 0; cr = 1; es = 0; er = 0;
      if (kind < 3) begin
        w = ($urandom_range(0, 3) == 0) ? 4095 : $urandom_range(0, 15);
        a = 32'(w) << 2;
        wr = ($urandom_range(0, 1) == 1) || !ref_mem.exists(w);
        rd = !wr;
        cr = rd;
        if (wr) ref_mem[w] = wd;
        else er = ref_mem[w];
      end else if (kind < 6) begin
        s = $urandom_range(0, NP - 1);
        a = 32'h4000 + 32'(s * 16) + 32'($urandom_range(0, 15));
        wr = $urandom_range(0, 1) == 1;
        rd = !wr;
        k = $urandom_range(0, TO + 3);
        es = k <= TO ? k + 2 : TO + 2;
        er = k > TO ? 32'hDEADBEEF : wr ? 32'h0 : pv;
        if (k > TO) begin
          st_to = 1;
          bump();
        end
      end else if (kind < 8) begin
        case ($urandom_range(0, 3))
          0: a = 32'h4041 + 32'($urandom_range(0, 2));
          1: a = 32'h4044 + 32'($urandom_range(0, 255));
          2: a = 32'h8000 + ($urandom & 32'h0FFF_FFFC);
          default: a = 32'hFFFF_FFFC;
        endcase
        wr = $urandom_range(0, 1) == 1;
        rd = !wr;
        cr = rd;
        st_um = 1;
        bump();
      end else if (kind == 8) begin
        a = 32'h4040;
        er = st_val();
      end else begin
        a = 32'h4040;
        rd = 0;
        wr = 1;
        cr = 0;
        st_um = 0; st_to = 0; st_ill = 0; st_cnt = 0;
      end
      run_txn(rd, wr, a, wd, k, pv, got, st, ok);
      chk("rnd_stall", st, es);
      if (cr) chk("rnd_rdata", got, er);
      chk("rnd_sig", 32'(ok), 1);
      if ($urandom_range(0, 3) == 0) idle_cycle();
    end
    idle_cycle();
    idle_cycle();
    chk("rnd_pulses", pulses - p0, exp_err);
    run_txn(1, 0, 32'h4040, 0, 0, 0, got, st, ok);
    chk("rnd_status", got, st_val());

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
